// File: rtl/dbus_wbuf_bridge_pkg.sv
// Shared types for the data-bus write-buffer bridge: FSM encodings, AXI constants and the
// write-buffer entry layout.
package dbus_wbuf_bridge_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

    typedef enum logic [1:0] {
        WIdle,
        WSend,
        WResp
    } wstate_e;

    typedef enum logic [2:0] {
        RIdle,
        RDrain,
        RAr,
        RR,
        RDone
    } rstate_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic [3:0]           strb;
        logic [1:0]           size;
    } wbuf_entry_t;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/dbus_wbuf_bridge_if.sv
// AXI3 master/slave channel bundle used between the bridge and the interconnect.
interface dbus_wbuf_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [DATA_W-1:0] axi_rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [3:0]        wid;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, axi_rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, axi_rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/dbus_wbuf_fifo.sv
// Synchronous FIFO for posted writes; DEPTH must be a power of two so pointers wrap naturally.
module dbus_wbuf_fifo
    import dbus_wbuf_bridge_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = wbuf_entry_t
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // Full is taken from the registered count, so a pop never frees a slot in the same cycle.
    assign full    = count_q[PTR_W];
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dbus_wbuf_bridge.sv
// Uncached AXI3 data-bus bridge: posted stores drain one at a time through a write buffer,
// loads wait behind every buffered or in-flight store and stall the pipeline until done.
module dbus_wbuf_bridge
    import dbus_wbuf_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W     = WB_ADDR_W,
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned WBUF_DEPTH = 4,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                req_en,
    input  logic [3:0]          req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_size,
    output logic [DATA_W-1:0]   rdata,
    output logic                stall,
    output logic                err,
    dbus_wbuf_bridge_if.master  axi
);

    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH) + 1;

    wstate_e           w_q, w_d;
    rstate_e           r_q, r_d;
    logic              aw_pend_q, aw_pend_d;
    logic              w_pend_q, w_pend_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    wbuf_entry_t       push_entry;
    wbuf_entry_t       head;
    logic              is_write;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              writes_idle;
    logic              r_err;
    logic              b_err;
    logic [CNT_W-1:0]  wbuf_count;
    logic              unused_axi;

    assign is_write    = |req_wen;
    assign push        = req_en & is_write & ~full;
    assign writes_idle = empty & (w_q == WIdle);
    assign unused_axi  = ^{axi.rid, axi.bid, wbuf_count};

    always_comb begin
        push_entry.addr = WB_ADDR_W'(req_addr);
        push_entry.data = WB_DATA_W'(req_wdata);
        push_entry.strb = req_wen;
        push_entry.size = req_size;
    end

    dbus_wbuf_fifo #(
        .DEPTH   (WBUF_DEPTH),
        .entry_t (wbuf_entry_t)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (wbuf_count)
    );

    // AW and W retire independently; the entry is popped only once B comes back.
    always_comb begin
        w_d       = w_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        pop       = 1'b0;
        b_err     = 1'b0;
        unique case (w_q)
            WIdle: begin
                if (!empty) begin
                    w_d       = WSend;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                end
            end
            WSend: begin
                if (axi.awready) aw_pend_d = 1'b0;
                if (axi.wready)  w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) w_d = WResp;
            end
            WResp: begin
                if (axi.bvalid) begin
                    pop   = 1'b1;
                    b_err = |axi.bresp;
                    w_d   = WIdle;
                end
            end
            default: w_d = WIdle;
        endcase
    end

    always_comb begin
        r_d     = r_q;
        rdata_d = rdata_q;
        r_err   = 1'b0;
        unique case (r_q)
            RIdle: begin
                if (req_en && !is_write) r_d = writes_idle ? RAr : RDrain;
            end
            RDrain: begin
                if (writes_idle) r_d = RAr;
            end
            RAr: begin
                if (axi.arready) r_d = RR;
            end
            RR: begin
                if (axi.rvalid && axi.rlast) begin
                    rdata_d = axi.axi_rdata;
                    r_err   = |axi.rresp;
                    r_d     = RDone;
                end
            end
            RDone:   r_d = RIdle;
            default: r_d = RIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_q       <= WIdle;
            r_q       <= RIdle;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            w_q       <= w_d;
            r_q       <= r_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rdata_q   <= rdata_d;
        end
    end

    // AR address/size come straight from the held request, which is stable while stalled.
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = req_addr;
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = axi_size(req_size);
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = (r_q == RAr);
    assign axi.rready  = 1'b1;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = ADDR_W'(head.addr);
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awsize  = axi_size(head.size);
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = aw_pend_q;

    assign axi.wid     = AXI_ID;
    assign axi.wdata   = DATA_W'(head.data);
    assign axi.wstrb   = head.strb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = w_pend_q;
    assign axi.bready  = 1'b1;

    assign rdata = rdata_q;
    assign err   = r_err | b_err;
    assign stall = req_en & ((is_write & full) | (~is_write & (r_q != RDone)));

endmodule

// File: tb/tb_dbus_wbuf_bridge.sv
// Directed bench for dbus_wbuf_bridge: read latency, write buffering, ordering, errors, reset.
module tb_dbus_wbuf_bridge;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_en;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    dbus_wbuf_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    dbus_wbuf_bridge #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .WBUF_DEPTH (4),
        .AXI_ID     (4'd0)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_en    (req_en),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .axi       (axi)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic mid();
        @(negedge aclk);
    endtask

    task automatic slave_init();
        axi.arready   = 1'b0;
        axi.rid       = 4'd0;
        axi.axi_rdata = 32'd0;
        axi.rresp     = 2'd0;
        axi.rlast     = 1'b0;
        axi.rvalid    = 1'b0;
        axi.awready   = 1'b0;
        axi.wready    = 1'b0;
        axi.bid       = 4'd0;
        axi.bresp     = 2'd0;
        axi.bvalid    = 1'b0;
    endtask

    task automatic set_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] wen, input logic [1:0] size);
        req_en    = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = data;
        req_size  = size;
    endtask

    task automatic set_load(input logic [31:0] addr);
        req_en   = 1'b1;
        req_wen  = 4'h0;
        req_addr = addr;
        req_size = 2'd2;
    endtask

    // Single read with arready=1 and R one cycle after the first R-wait cycle.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input string tag);
        int stalls;
        stalls = 0;
        set_load(addr);
        axi.arready = 1'b1;
        mid();
        if (stall) stalls++;
        chk({tag, "_c0_arvalid"}, axi.arvalid, 1'b0);
        tick();
        mid();
        if (stall) stalls++;
        chk({tag, "_arvalid"}, axi.arvalid, 1'b1);
        chk({tag, "_araddr"}, axi.araddr, addr);
        chk({tag, "_arsize"}, axi.arsize, 3'd2);
        tick();
        mid();
        if (stall) stalls++;
        chk({tag, "_ar_drop"}, axi.arvalid, 1'b0);
        tick();
        axi.rvalid    = 1'b1;
        axi.rlast     = 1'b1;
        axi.axi_rdata = data;
        axi.rresp     = resp;
        mid();
        if (stall) stalls++;
        chk({tag, "_err_on_r"}, err, (resp != 2'd0));
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'd0;
        mid();
        chk({tag, "_done_stall"}, stall, 1'b0);
        chk({tag, "_stall_cycles"}, stalls, 4);
        chk({tag, "_rdata"}, rdata, data);
        tick();
        req_en      = 1'b0;
        axi.arready = 1'b0;
        mid();
        chk({tag, "_rdata_hold"}, rdata, data);
        chk({tag, "_err_clear"}, err, 1'b0);
        chk({tag, "_no_reissue"}, axi.arvalid, 1'b0);
    endtask

    // Accept the next AW/W pair (bounded wait), then return B with the given response.
    task automatic drain_one(input logic [31:0] ea, input logic [31:0] ed,
                             input logic [1:0] br, input string tag);
        int n;
        n = 0;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.bvalid  = 1'b0;
        mid();
        while (!(axi.awvalid && axi.wvalid) && n < 16) begin
            tick();
            mid();
            n++;
        end
        chk({tag, "_awvalid"}, axi.awvalid, 1'b1);
        chk({tag, "_awaddr"}, axi.awaddr, ea);
        chk({tag, "_wdata"}, axi.wdata, ed);
        tick();
        axi.bvalid = 1'b1;
        axi.bresp  = br;
        mid();
        chk({tag, "_aw_drop"}, axi.awvalid, 1'b0);
        chk({tag, "_berr"}, err, (br != 2'd0));
        tick();
        axi.bvalid = 1'b0;
        axi.bresp  = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn   = 1'b0;
        req_en    = 1'b0;
        req_wen   = 4'h0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_size  = 2'd2;
        slave_init();
        repeat (2) @(posedge aclk);
        #1;
        mid();
        chk("rst_arvalid", axi.arvalid, 1'b0);
        chk("rst_awvalid", axi.awvalid, 1'b0);
        chk("rst_wvalid", axi.wvalid, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_stall_idle", stall, 1'b0);
        chk("const_ready", {axi.rready, axi.bready, axi.wlast}, 3'b111);
        chk("const_ar", {axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
            {4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        req_en = 1'b1;
        #1;
        chk("rst_stall_follows_req", stall, 1'b1);
        req_en = 1'b0;
        tick();
        aresetn = 1'b1;

        // Minimum-latency read.
        do_read(32'h1FC0_0010, 32'hDEAD_BEEF, 2'd0, "rd1");

        // Five back-to-back stores into a 4-deep buffer with the slave not ready.
        tick();
        for (int i = 0; i < 5; i++) begin
            set_store(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 2'd2);
            mid();
            if (i < 4) begin
                chk("st_no_stall", stall, 1'b0);
                tick();
            end
        end
        chk("st5_stall", stall, 1'b1);
        chk("st_head_awvalid", axi.awvalid, 1'b1);
        chk("st_head_awaddr", axi.awaddr, 32'h200);
        chk("st_head_wdata", axi.wdata, 32'hA0);
        tick();
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        mid();
        chk("st5_full_hold", stall, 1'b1);
        tick();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b1;
        mid();
        chk("st5_no_bypass", stall, 1'b1);
        chk("st_aw_dropped", axi.awvalid, 1'b0);
        tick();
        axi.bvalid = 1'b0;
        mid();
        chk("st5_accepted", stall, 1'b0);
        tick();
        req_en = 1'b0;
        drain_one(32'h204, 32'hA1, 2'd0, "d1");
        drain_one(32'h208, 32'hA2, 2'd0, "d2");
        drain_one(32'h20C, 32'hA3, 2'd0, "d3");
        drain_one(32'h210, 32'hA4, 2'd0, "d4");
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        mid();
        tick();
        mid();
        chk("drained_empty", axi.awvalid, 1'b0);

        // Store then load to the same address: AR waits for B; no forwarding.
        tick();
        set_store(32'h100, 32'h1122_3344, 4'hF, 2'd2);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.arready = 1'b1;
        mid();
        chk("sl_store_stall", stall, 1'b0);
        tick();
        set_load(32'h100);
        mid();
        chk("sl_load_stall", stall, 1'b1);
        chk("sl_ar_blocked0", axi.arvalid, 1'b0);
        tick();
        mid();
        chk("sl_awvalid", axi.awvalid, 1'b1);
        chk("sl_wdata", axi.wdata, 32'h1122_3344);
        chk("sl_ar_blocked1", axi.arvalid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            mid();
            chk("sl_ar_wait_b", axi.arvalid, 1'b0);
        end
        tick();
        axi.bvalid = 1'b1;
        mid();
        chk("sl_ar_at_b", axi.arvalid, 1'b0);
        tick();
        axi.bvalid = 1'b0;
        mid();
        chk("sl_ar_after_b", axi.arvalid, 1'b0);
        tick();
        mid();
        chk("sl_ar_issued", axi.arvalid, 1'b1);
        chk("sl_araddr", axi.araddr, 32'h100);
        tick();
        axi.arready   = 1'b0;
        axi.rvalid    = 1'b1;
        axi.rlast     = 1'b1;
        axi.rresp     = 2'b11;
        axi.axi_rdata = 32'h5566_7788;
        mid();
        chk("sl_rerr_pulse", err, 1'b1);
        chk("sl_r_stall", stall, 1'b1);
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
        mid();
        chk("sl_done_stall", stall, 1'b0);
        chk("sl_rdata_captured", rdata, 32'h5566_7788);
        chk("sl_rerr_one_cycle", err, 1'b0);
        tick();
        req_en      = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;

        // Independent AW/W handshakes and a SLVERR write response.
        set_store(32'h300, 32'hCAFE_F00D, 4'h3, 2'd1);
        mid();
        chk("hs_store_stall", stall, 1'b0);
        tick();
        req_en = 1'b0;
        mid();
        chk("hs_idle_aw", axi.awvalid, 1'b0);
        tick();
        mid();
        chk("hs_c0_valids", {axi.awvalid, axi.wvalid}, 2'b11);
        chk("hs_awsize", axi.awsize, 3'd1);
        chk("hs_wstrb", axi.wstrb, 4'h3);
        tick();
        axi.awready = 1'b1;
        mid();
        chk("hs_c1_valids", {axi.awvalid, axi.wvalid}, 2'b11);
        tick();
        axi.awready = 1'b0;
        axi.bvalid  = 1'b1;
        axi.bresp   = 2'b10;
        mid();
        chk("hs_c2_valids", {axi.awvalid, axi.wvalid}, 2'b01);
        chk("hs_early_b_ignored", err, 1'b0);
        tick();
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        axi.wready = 1'b1;
        mid();
        chk("hs_c3_valids", {axi.awvalid, axi.wvalid}, 2'b01);
        tick();
        axi.wready = 1'b0;
        mid();
        chk("hs_resp_valids", {axi.awvalid, axi.wvalid}, 2'b00);
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b10;
        #1;
        chk("hs_berr_pulse", err, 1'b1);
        tick();
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        mid();
        chk("hs_berr_one_cycle", err, 1'b0);
        tick();
        mid();
        chk("hs_popped", axi.awvalid, 1'b0);

        // Reset while a read waits in R with three stores buffered.
        tick();
        set_load(32'h400);
        axi.arready = 1'b1;
        mid();
        chk("rr_stall", stall, 1'b1);
        tick();
        mid();
        chk("rr_arvalid", axi.arvalid, 1'b1);
        tick();
        axi.arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_store(32'h500 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF, 2'd2);
            mid();
            chk("rr_push", stall, 1'b0);
            tick();
        end
        req_en = 1'b0;
        mid();
        chk("rr_pre_reset_aw", axi.awvalid, 1'b1);
        tick();
        aresetn = 1'b0;
        slave_init();
        mid();
        chk("rr_rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 3'b000);
        chk("rr_rst_rdata", rdata, 32'd0);
        chk("rr_rst_err", err, 1'b0);
        tick();
        aresetn = 1'b1;
        mid();
        chk("rr_post_aw0", axi.awvalid, 1'b0);
        tick();
        mid();
        chk("rr_post_aw1", axi.awvalid, 1'b0);
        chk("rr_post_ar", axi.arvalid, 1'b0);
        tick();
        do_read(32'h1FC0_0020, 32'h0BAD_F00D, 2'd0, "rd2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
